sync_driver_rx: RTL
===================

// Module: sync_driver_rx
// PURPOSE
//  Receive-side model of the LED driver serial port: samples SCLK/SIN/LAT/mux_en as the
//  synchronizer and led band controller drive them, rebuilds each latched frame and streams it out
//  as channel words. Used as on-FPGA loopback checker and as bench reference; sits beside driver pins.
// PARAMETERS
//  NB_CHANNELS    48  channels per driver frame
//  CHANNEL_WIDTH  16  bits per channel word
//  SYNC_STAGES    2   flops in each input synchronizer (>=2)
//  SHIFT_WIDTH    NB_CHANNELS*CHANNEL_WIDTH+1 (localparam); MSB = frame select bit (1=FC, 0=GS)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active high
//  SCLK         in   1   serial clock (generated or HPS override; treated as asynchronous)
//  SIN          in   1   serial data, MSB first, valid at SCLK rising edge
//  LAT          in   1   latch strobe
//  mux_en       in   4   multiplexing enables
//  word_valid   out  1   stream word valid
//  word_ready   in   1   stream word ready
//  word_data    out  CHANNEL_WIDTH  channel word
//  word_idx     out  $clog2(NB_CHANNELS)  channel index of word_data
//  word_last    out  1   high with word_idx==0
//  frame_is_fc  out  1   select bit of frame being streamed
//  frame_err    out  1   one-cycle pulse: LAT with bit count != SHIFT_WIDTH
//  overrun      out  1   one-cycle pulse: valid LAT while still streaming
// BEHAVIOUR
//  - Reset: all outputs 0; shift register, bit counter, holding buffer cleared; state IDLE.
//  - SCLK/SIN/LAT each pass SYNC_STAGES flops; SIN taken from same stage as SCLK; rising edge
//    detected from last two stages. Requires SCLK high and low each >= SYNC_STAGES+1 clk.
//  - SCLK rise: shift {shreg[SHIFT_WIDTH-2:0],SIN}; bit_cnt increments, saturates at SHIFT_WIDTH+1.
//  - LAT rise: bit_cnt==SHIFT_WIDTH and state IDLE -> copy shreg to hold buffer, go STREAM next cycle;
//    bit_cnt!=SHIFT_WIDTH -> frame_err pulse, frame dropped; valid count but state STREAM -> overrun
//    pulse, new frame dropped, current stream undisturbed. bit_cnt cleared to 0 in all cases.
//  - Same-cycle SCLK rise and LAT rise: shift applied first; LAT checks the updated count.
//  - FSM: IDLE -(valid LAT)-> STREAM -(word_valid&&word_ready&&word_last)-> IDLE.
//  - STREAM: channel k = hold[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]; words emitted idx NB_CHANNELS-1
//    down to 0; word_valid asserted 1 clk after latch decision; once high, word_* stable until
//    accepted (AXI-style, no valid drop). frame_is_fc = hold[SHIFT_WIDTH-1], held for whole frame.
//  - Latency LAT pin rise -> first word_valid: SYNC_STAGES+2 clk.
//  - Reset asserted mid-frame or mid-stream: immediate abort, no pulses, stream restarts clean.
//  - mux_en sampled through synchronizer only when MUX_TAG feature compiled in.
// CONFIGURATION
//  SYNC_DRIVER_RX_MUX_TAG_EN defined: extra output word_mux [3:0] = mux_en (synchronized) captured
//  at the accepted LAT edge, held for the frame; 0 at reset.
//  Undefined: no word_mux port; mux_en input unused.
// STRUCTURE
//  - sync_pkg: rx FSM enum (IDLE, STREAM), SHIFT_WIDTH/index-width helper functions.
//  - One sub-module: sync_edge_detect (param STAGES; ports clk, rst, d, q, rise) instantiated
//    for SCLK and LAT; SIN and mux_en use plain synchronizer flops.
// TESTING
//  1 Reset: rst high with SCLK toggling -> all outputs 0, no word_valid after rst drop.
//  2 GS frame: 769 bits, MSB 0, channel k = 16'hA500+k, LAT, word_ready=1 -> 48 words
//    idx 47..0, data 16'hA52F..16'hA500, frame_is_fc=0, word_last only on idx 0.
//  3 FC frame + backpressure: MSB 1, word_ready toggling 1-of-3 -> frame_is_fc=1, words stable
//    while stalled, no loss/duplication.
//  4 Length error: 768 bits then LAT -> frame_err one pulse, no word_valid; 770 bits -> same.
//  5 Overrun: valid frame, word_ready=0, second valid frame+LAT -> overrun pulse, first frame
//    intact afterward, second never streamed.
//  6 Async reset mid-stream after 10 words -> outputs 0 within same cycle; next frame streams fully.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types and sizing helpers for the LED driver serial receive model.
package sync_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rx_state_e;

  // Full frame length: all channel words plus the leading FC/GS select bit.
  function automatic int unsigned shift_width(input int unsigned nb_channels,
                                              input int unsigned channel_width);
    return nb_channels * channel_width + 1;
  endfunction

  // Width of a channel index (at least one bit).
  function automatic int unsigned idx_width(input int unsigned nb_channels);
    return (nb_channels > 1) ? $clog2(nb_channels) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop input synchronizer with rising-edge detect on the synchronized level.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next values: shift the pin into the chain, remember the last stage.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer chain and edge history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/sync_driver_rx.sv
// Receive-side model of the LED driver serial port: rebuilds latched frames from
// SCLK/SIN/LAT and streams them out as channel words, highest index first.
// Optional feature macro: SYNC_DRIVER_RX_MUX_TAG_EN adds word_mux (synchronized
// mux_en captured at the accepted latch).
module sync_driver_rx
  import sync_pkg::*;
#(
  parameter int unsigned NB_CHANNELS   = 48,
  parameter int unsigned CHANNEL_WIDTH = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 SCLK,
  input  logic                                 SIN,
  input  logic                                 LAT,
  input  logic [3:0]                           mux_en,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [CHANNEL_WIDTH-1:0]             word_data,
  output logic [idx_width(NB_CHANNELS)-1:0]    word_idx,
  output logic                                 word_last,
  output logic                                 frame_is_fc,
  output logic                                 frame_err,
`ifdef SYNC_DRIVER_RX_MUX_TAG_EN
  output logic [3:0]                           word_mux,
`endif
  output logic                                 overrun
);

  localparam int unsigned SHIFT_WIDTH = shift_width(NB_CHANNELS, CHANNEL_WIDTH);
  localparam int unsigned IDX_W       = idx_width(NB_CHANNELS);
  localparam int unsigned CNT_W       = $clog2(SHIFT_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHIFT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SHIFT_WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NB_CHANNELS - 1);

  logic sclk_lvl, sclk_rise, lat_lvl, lat_rise;
  logic [SYNC_STAGES-1:0] sin_sync_q;

  rx_state_e                state_q, state_d;
  logic [SHIFT_WIDTH-1:0]   shreg_q, shreg_d, shreg_upd;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d, cnt_upd;
  logic [SHIFT_WIDTH-1:0]   hold_q, hold_d;
  logic                     word_valid_q, word_valid_d;
  logic [CHANNEL_WIDTH-1:0] word_data_q, word_data_d;
  logic [IDX_W-1:0]         word_idx_q, word_idx_d, sel_idx;
  logic                     word_last_q, word_last_d;
  logic                     frame_is_fc_q, frame_is_fc_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (SCLK),
    .q    (sclk_lvl),
    .rise (sclk_rise)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lat_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (LAT),
    .q    (lat_lvl),
    .rise (lat_rise)
  );

  // SIN chain has the same depth as SCLK so the sampled bit lines up with the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sin_sync_q <= '0;
    else     sin_sync_q <= {sin_sync_q[SYNC_STAGES-2:0], SIN};
  end

`ifdef SYNC_DRIVER_RX_MUX_TAG_EN
  logic [3:0] mux_s1_q, mux_s2_q, word_mux_q, word_mux_d;

  // Two-flop synchronizer for the mux enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_s1_q <= '0;
      mux_s2_q <= '0;
    end else begin
      mux_s1_q <= mux_en;
      mux_s2_q <= mux_s1_q;
    end
  end
  assign word_mux = word_mux_q;
  logic unused_lvl;
  assign unused_lvl = sclk_lvl ^ lat_lvl;
`else
  logic unused_lvl;
  assign unused_lvl = sclk_lvl ^ lat_lvl ^ (^mux_en);
`endif

  // Next-state logic: shift on SCLK, latch decision on LAT (after the shift), stream words.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    word_valid_d  = word_valid_q;
    word_data_d   = word_data_q;
    word_idx_d    = word_idx_q;
    word_last_d   = word_last_q;
    frame_is_fc_d = frame_is_fc_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;
    sel_idx       = '0;
`ifdef SYNC_DRIVER_RX_MUX_TAG_EN
    word_mux_d    = word_mux_q;
`endif

    shreg_upd = shreg_q;
    cnt_upd   = bit_cnt_q;
    if (sclk_rise) begin
      shreg_upd = {shreg_q[SHIFT_WIDTH-2:0], sin_sync_q[SYNC_STAGES-1]};
      if (bit_cnt_q != CNT_SAT) cnt_upd = bit_cnt_q + 1'b1;
    end
    shreg_d   = shreg_upd;
    bit_cnt_d = cnt_upd;

    if (state_q == STREAM) begin
      if (!word_valid_q) begin
        sel_idx      = word_idx_q;
        word_valid_d = 1'b1;
        word_data_d  = hold_q[int'(sel_idx) * CHANNEL_WIDTH +: CHANNEL_WIDTH];
        word_last_d  = (sel_idx == '0);
      end else if (word_ready) begin
        if (word_last_q) begin
          word_valid_d = 1'b0;
          word_last_d  = 1'b0;
          state_d      = IDLE;
        end else begin
          sel_idx     = word_idx_q - 1'b1;
          word_idx_d  = sel_idx;
          word_data_d = hold_q[int'(sel_idx) * CHANNEL_WIDTH +: CHANNEL_WIDTH];
          word_last_d = (sel_idx == '0);
        end
      end
    end

    if (lat_rise) begin
      bit_cnt_d = '0;
      if (cnt_upd != CNT_FULL) begin
        frame_err_d = 1'b1;
      end else if (state_q == STREAM) begin
        overrun_d = 1'b1;
      end else begin
        hold_d        = shreg_upd;
        state_d       = STREAM;
        word_idx_d    = IDX_TOP;
        frame_is_fc_d = shreg_upd[SHIFT_WIDTH-1];
`ifdef SYNC_DRIVER_RX_MUX_TAG_EN
        word_mux_d    = mux_s2_q;
`endif
      end
    end
  end

  // Receive FSM with registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      hold_q        <= '0;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_idx_q    <= '0;
      word_last_q   <= 1'b0;
      frame_is_fc_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SYNC_DRIVER_RX_MUX_TAG_EN
      word_mux_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      word_valid_q  <= word_valid_d;
      word_data_q   <= word_data_d;
      word_idx_q    <= word_idx_d;
      word_last_q   <= word_last_d;
      frame_is_fc_q <= frame_is_fc_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
`ifdef SYNC_DRIVER_RX_MUX_TAG_EN
      word_mux_q    <= word_mux_d;
`endif
    end
  end

  assign word_valid  = word_valid_q;
  assign word_data   = word_data_q;
  assign word_idx    = word_idx_q;
  assign word_last   = word_last_q;
  assign frame_is_fc = frame_is_fc_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule
